// File: rtl/fp_iter_sequencer_pkg.sv
// Shared definitions for the iteration sequencer: counter width, FSM state
// encoding and the helper that resolves a requested iteration count.
package fp_iter_pkg;

    // Width of the iteration counter and of the iter_cnt / remaining ports.
    localparam int ITER_W = 6;

    // Sequencer states. The unused encoding 2'b11 is recovered to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } iter_state_t;

    // A request of zero iterations selects the configured default count.
    function automatic logic [ITER_W-1:0] resolve_iter(
        input logic [ITER_W-1:0] req,
        input logic [ITER_W-1:0] dflt
    );
        logic [ITER_W-1:0] res;
        if (req == {ITER_W{1'b0}}) begin
            res = dflt;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage : fp_iter_pkg

// File: rtl/fp_iter_sequencer_counter.sv
// iter_down_counter: loadable, enable-gated down counter for the iteration
// sequencer. Asynchronous active-high clear (rst_i) plus a synchronous clear
// (clr_i). Priority: clr_i > load_i > en_i. The count saturates at zero so a
// stray enable can never wrap it to the maximum value.
module iter_down_counter
    import fp_iter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [ITER_W-1:0] load_val_i,
    input  logic              en_i,
    output logic [ITER_W-1:0] count_o
);

    logic [ITER_W-1:0] count_q;
    logic [ITER_W-1:0] count_d;

    // Next count: clear, load, or saturating decrement.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {ITER_W{1'b0}};
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != {ITER_W{1'b0}})) begin
            count_d = count_q - {{(ITER_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {ITER_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : iter_down_counter

// File: rtl/fp_iter_sequencer.sv
// fp_iter_sequencer: drives an iterative floating-point datapath.
// A start request loads the iteration counter (iter_cnt, or DEFAULT_ITER when
// iter_cnt is zero); the sequencer then issues one step_en per cycle, flags
// the final iteration with last_step and finishes with a one-cycle done pulse.
// abort returns to IDLE without a done pulse and always wins over start.
//
// Build option: define FP_ITER_STALL_EN to add the stall input. While stall
// is high in RUN the step strobe is suppressed and counter/state are held.
// Without the macro the port does not exist and RUN advances every cycle.
//
// Outputs are decoded straight from the state and counter flops (plus the
// stall input when enabled), so an asynchronous rst clears them immediately.
module fp_iter_sequencer
    import fp_iter_pkg::*;
#(
    parameter logic [ITER_W-1:0] DEFAULT_ITER = 6'd24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] iter_cnt,
    input  logic              abort,
`ifdef FP_ITER_STALL_EN
    input  logic              stall,
`endif
    output logic              busy,
    output logic              step_en,
    output logic              last_step,
    output logic              done,
    output logic [ITER_W-1:0] remaining
);

    iter_state_t       state_q;
    iter_state_t       state_d;

    logic              cnt_clr;
    logic              cnt_load;
    logic              cnt_en;
    logic              stall_act;
    logic [ITER_W-1:0] load_val;
    logic [ITER_W-1:0] cnt_val;

`ifdef FP_ITER_STALL_EN
    assign stall_act = stall;
`else
    assign stall_act = 1'b0;
`endif

    assign load_val = resolve_iter(iter_cnt, DEFAULT_ITER);

    // Next-state and counter-control decode; abort has top priority.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    // abort together with start keeps the block idle
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (start) begin
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (stall_act) begin
                    state_d = RUN;
                end else if (cnt_val <= 6'd1) begin
                    // final iteration (<= also rescues an impossible zero count)
                    state_d = DONE;
                    cnt_en  = 1'b1;
                end else begin
                    state_d = RUN;
                    cnt_en  = 1'b1;
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (start) begin
                    // back-to-back run, no idle gap
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration counter; its value is the remaining output.
    iter_down_counter u_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (load_val),
        .en_i       (cnt_en),
        .count_o    (cnt_val)
    );

    // Output decode from the state and counter flops.
    always_comb begin
        busy      = 1'b0;
        step_en   = 1'b0;
        last_step = 1'b0;
        done      = 1'b0;
        remaining = cnt_val;
        if (state_q == RUN) begin
            busy      = 1'b1;
            step_en   = ~stall_act;
            last_step = ~stall_act && (cnt_val == 6'd1);
        end else if (state_q == DONE) begin
            busy = 1'b1;
            done = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

endmodule : fp_iter_sequencer

// File: tb/tb_fp_iter_sequencer.sv
// Self-checking bench for fp_iter_sequencer. Directed scenarios use expected
// values written from the cycle-by-cycle behaviour; the random scenario uses a
// schedule-queue reference model (each accepted start enqueues the remaining
// values N..1 followed by a done marker 0).
module tb_fp_iter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] iter_cnt;
    logic       abort;
`ifdef FP_ITER_STALL_EN
    logic       stall;
`endif
    logic       busy;
    logic       step_en;
    logic       last_step;
    logic       done;
    logic [5:0] remaining;

    int total = 0;
    int bad   = 0;

    localparam int DEF_ITER = 24;

    fp_iter_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .iter_cnt  (iter_cnt),
        .abort     (abort),
`ifdef FP_ITER_STALL_EN
        .stall     (stall),
`endif
        .busy      (busy),
        .step_en   (step_en),
        .last_step (last_step),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    wire [9:0] obs = {busy, step_en, last_step, done, remaining};

    function automatic logic [9:0] ev(input logic b, input logic s, input logic l,
                                      input logic d, input logic [5:0] r);
        return {b, s, l, d, r};
    endfunction

    // Move one rising edge forward; inputs are driven at +1, sampled at +2.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start    = 1'b0;
        abort    = 1'b0;
        iter_cnt = 6'd0;
`ifdef FP_ITER_STALL_EN
        stall    = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [9:0] e;
        rst = 1'b1;
        drive_idle();
        #3;
        e = ev(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_async got=%b exp=%b", obs, e);
        end
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        #1;
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=%b", obs, e);
        end
    endtask

    task automatic test_basic();
        logic [9:0] e;
        start = 1'b1; iter_cnt = 6'd5;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            start = 1'b0;
            #1;
            e = ev(c <= 6, c <= 5, c == 5, c == 6, (c <= 5) ? 6'(6 - c) : 6'd0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL basic5 cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
    endtask

    task automatic test_default();
        logic [9:0] e;
        start = 1'b1; iter_cnt = 6'd0;
        for (int c = 1; c <= DEF_ITER + 2; c++) begin
            cyc();
            start = 1'b0;
            #1;
            e = ev(c <= DEF_ITER + 1, c <= DEF_ITER, c == DEF_ITER, c == DEF_ITER + 1,
                   (c <= DEF_ITER) ? 6'(DEF_ITER + 1 - c) : 6'd0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL default_iter cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        int p;
        start = 1'b1; iter_cnt = 6'd3;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            start = (c < 8);
            #1;
            p = ((c - 1) % 4) + 1;
            if (c == 9) e = ev(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            else e = ev(1'b1, p <= 3, p == 3, p == 4, (p <= 3) ? 6'(4 - p) : 6'd0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_abort();
        logic [9:0] e;
        start = 1'b1; iter_cnt = 6'd10;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            start = 1'b0;
            abort = (c == 4);
            #1;
            if (c <= 4) e = ev(1'b1, 1'b1, 1'b0, 1'b0, 6'(11 - c));
            else        e = ev(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL abort_run cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
        abort = 1'b1; start = 1'b1; iter_cnt = 6'd4;
        for (int c = 1; c <= 2; c++) begin
            cyc();
            abort = 1'b0; start = 1'b0;
            #1;
            e = ev(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL abort_start_idle cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] e;
        start = 1'b1; iter_cnt = 6'd10;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            start = 1'b0;
            #1;
            e = ev(1'b1, 1'b1, 1'b0, 1'b0, 6'(11 - c));
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL rst_prerun cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        e = ev(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL rst_midrun got=%b exp=%b", obs, e);
        end
        cyc();
        rst = 1'b0;
        start = 1'b1; iter_cnt = 6'd2;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            start = 1'b0;
            #1;
            e = ev(c <= 3, c <= 2, c == 2, c == 3, (c <= 2) ? 6'(3 - c) : 6'd0);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL rst_restart cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
    endtask

`ifdef FP_ITER_STALL_EN
    task automatic test_stall();
        logic [9:0] e;
        int          r;
        start = 1'b1; iter_cnt = 6'd4;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            start = 1'b0;
            stall = (c == 2) || (c == 3);
            #1;
            r = (c == 1) ? 4 : (c <= 4) ? 3 : (c == 5) ? 2 : (c == 6) ? 1 : 0;
            e = ev(c <= 7, (c == 1) || (c >= 4 && c <= 6), c == 6, c == 7, 6'(r));
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL stall cyc=%0d got=%b exp=%b", c, obs, e);
            end
        end
        stall = 1'b0;
    endtask
`endif

    task automatic test_random();
        int         sched[$];
        logic [9:0] e;
        logic       st;
        int         n;
        for (int k = 0; k < 800; k++) begin
            cyc();
            start    = ($urandom_range(0, 2) == 0);
            iter_cnt = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 9));
            abort    = ($urandom_range(0, 24) == 0);
`ifdef FP_ITER_STALL_EN
            stall    = ($urandom_range(0, 3) == 0);
            st       = stall;
`else
            st       = 1'b0;
`endif
            #1;
            if (sched.size() == 0)  e = ev(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            else if (sched[0] == 0) e = ev(1'b1, 1'b0, 1'b0, 1'b1, 6'd0);
            else e = ev(1'b1, !st, !st && (sched[0] == 1), 1'b0, 6'(sched[0]));
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL random k=%0d got=%b exp=%b", k, obs, e);
            end
            // apply the upcoming clock edge to the schedule
            if (abort) begin
                sched.delete();
            end else if (sched.size() == 0 || sched[0] == 0) begin
                sched.delete();
                if (start) begin
                    n = (iter_cnt == 6'd0) ? DEF_ITER : int'(iter_cnt);
                    for (int j = n; j >= 1; j--) sched.push_back(j);
                    sched.push_back(0);
                end
            end else if (!st) begin
                void'(sched.pop_front());
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_default();
        test_back_to_back();
        test_abort();
        test_async_reset();
`ifdef FP_ITER_STALL_EN
        test_stall();
`endif
        // let any run finish before the model starts from an empty schedule
        for (int c = 0; c < 30; c++) cyc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fp_iter_sequencer

// File: doc/fp_iter_sequencer.md
FP_ITER_SEQUENCER -- requirements
Module: fp_iter_sequencer

Interface
REQ-001 Parameter: DEFAULT_ITER, default 6'd24, iteration count used when start arrives with iter_cnt == 0.
REQ-002 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: start  input  1  request a new iteration run; sampled only in IDLE or DONE.
REQ-005 Port: iter_cnt  input  6  requested number of iterations (1..63; 0 selects DEFAULT_ITER).
REQ-006 Port: abort  input  1  cancel the current run.
REQ-007 Port: stall  input  1  hold the current iteration; present only when FP_ITER_STALL_EN is defined.
REQ-008 Port: busy  output  1  high while state != IDLE.
REQ-009 Port: step_en  output  1  datapath iteration strobe; one iteration per high cycle.
REQ-010 Port: last_step  output  1  high with step_en on the final iteration.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: remaining  output  6  iterations still to execute (current counter value).

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE + start -> RUN; counter loads iter_cnt, or DEFAULT_ITER if iter_cnt == 0.
REQ-015 RUN: step_en = 1 each cycle; counter decrements by 1 each cycle; last_step = (remaining == 1).
REQ-016 RUN with remaining == 1 -> DONE; counter becomes 0.
REQ-017 DONE: done = 1 for exactly that cycle; without start -> IDLE; with start -> RUN (reload per REQ-014, back-to-back).
REQ-018 Latency: start in cycle 0 with N -> step_en in cycles 1..N, done in cycle N+1.
REQ-019 start while in RUN SHALL be ignored, with no effect on counter or outputs.
REQ-020 abort in RUN or DONE -> IDLE next cycle; counter cleared; no done pulse is generated for an aborted run.
REQ-021 abort and start in the same cycle: abort wins; the block ends in IDLE.
REQ-022 The counter SHALL never wrap below 0; a decrement is enabled only in RUN with remaining > 0.
REQ-023 step_en, last_step and done SHALL be 0 in IDLE.

Reset
REQ-024 Asserting rst SHALL immediately force state = IDLE, remaining = 0, busy = step_en = last_step = done = 0, independent of clk.
REQ-025 Reset mid-run SHALL discard the run with no done pulse; the first start after rst deasserts is accepted normally.

Configuration
REQ-026 Macro FP_ITER_STALL_EN: when defined, the stall port exists; stall = 1 in RUN forces step_en = last_step = 0 and holds the counter and state.
REQ-027 With FP_ITER_STALL_EN defined, abort SHALL still take priority over stall.
REQ-028 Without FP_ITER_STALL_EN, the stall port and its logic are absent, and RUN advances every cycle.

Structure
REQ-029 Package fp_iter_pkg SHALL hold ITER_W = 6 and the state enum iter_state_t {IDLE, RUN, DONE}.
REQ-030 Sub-module iter_down_counter SHALL be a synchronous, loadable, enable-gated 6-bit down counter with async active-high clear, instantiated once.
REQ-031 All flops SHALL share clk, with no derived or ripple clocks.

Verification
REQ-032 rst, then start with iter_cnt = 5 -> step_en in cycles 1-5, last_step in cycle 5, done in cycle 6, busy low in cycle 7.
REQ-033 start with iter_cnt = 0 -> 24 step_en cycles; remaining reads 24 in cycle 1 and 1 in cycle 24.
REQ-034 iter_cnt = 3, start held high continuously -> done in cycle 4 with reload; step_en high in cycles 5-7; no gap between runs.
REQ-035 iter_cnt = 10, abort in cycle 4 -> IDLE in cycle 5, remaining = 0, no done pulse; abort + start in IDLE -> stays IDLE.
REQ-036 rst asserted asynchronously in cycle 3 of a 10-iteration run -> outputs 0 before the next clk edge; restart with 2 -> done in cycle 3.
REQ-037 FP_ITER_STALL_EN defined, iter_cnt = 4, stall high in cycles 2-3 -> step_en in cycles 1, 4, 5, 6; done in cycle 7.
